// File: rtl/i2c_slave_if.sv
// I2C responder bus bundle: raw bus pins, the open-drain SDA enable and the
// local byte handshake towards the logic that consumes and supplies data.
interface i2c_slave_if;
  logic       scl;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       busy;
  logic       rw_flag;

  modport slave (
    input  scl, sda_in, tx_data,
    output sda_oe, rx_data, rx_valid, tx_load, busy, rw_flag
  );

  modport master (
    output scl, sda_in, tx_data,
    input  sda_oe, rx_data, rx_valid, tx_load, busy, rw_flag
  );
endinterface

// File: rtl/i2c_slave.sv
// I2C responder: oversamples SCL/SDA on clk, detects START/STOP, matches a
// 7-bit address, receives bytes on writes and transmits local bytes on reads.
// SDA is open-drain: sda_oe=1 pulls the wire low.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input logic        clk,
  input logic        reset,
  i2c_slave_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWrData,
    StWrAck,
    StRdData,
    StRdAck,
    StRdWait
  } state_e;

  // Synchroniser and previous-value registers
  logic r_scl_s1, r_scl_s2, r_scl_prev;
  logic r_sda_s1, r_sda_s2, r_sda_prev;

  // FSM and datapath registers
  state_e     r_state;
  logic [3:0] r_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_tx_shift;
  logic       r_sda_oe;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_tx_load;
  logic       r_busy;
  logic       r_rw_flag;

  // Next-state values
  state_e     w_state_nxt;
  logic [3:0] w_cnt_nxt;
  logic [7:0] w_shift_nxt;
  logic [7:0] w_tx_shift_nxt;
  logic       w_sda_oe_nxt;
  logic [7:0] w_rx_data_nxt;
  logic       w_rx_valid_nxt;
  logic       w_tx_load_nxt;
  logic       w_busy_nxt;
  logic       w_rw_flag_nxt;

  // Bus events derived from synced pins
  logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda;

  assign w_sda      = r_sda_s2;
  assign w_scl_rise = r_scl_s2 & ~r_scl_prev;
  assign w_scl_fall = ~r_scl_s2 & r_scl_prev;
  assign w_start    = r_scl_s2 & r_sda_prev & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & ~r_sda_prev & r_sda_s2;

  // Two-flop synchronisers; reset high to match an idle pulled-up bus
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scl_s1   <= 1'b1;
      r_scl_s2   <= 1'b1;
      r_scl_prev <= 1'b1;
      r_sda_s1   <= 1'b1;
      r_sda_s2   <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_s1   <= bus.scl;
      r_scl_s2   <= r_scl_s1;
      r_scl_prev <= r_scl_s2;
      r_sda_s1   <= bus.sda_in;
      r_sda_s2   <= r_sda_s1;
      r_sda_prev <= r_sda_s2;
    end
  end

  // FSM state and datapath register update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_cnt      <= 4'd0;
      r_shift    <= 8'h00;
      r_tx_shift <= 8'h00;
      r_sda_oe   <= 1'b0;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_tx_load  <= 1'b0;
      r_busy     <= 1'b0;
      r_rw_flag  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_tx_load  <= w_tx_load_nxt;
      r_busy     <= w_busy_nxt;
      r_rw_flag  <= w_rw_flag_nxt;
    end
  end

  // Next-state logic; STOP beats START, and both beat bit handling
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_shift_nxt    = r_shift;
    w_tx_shift_nxt = r_tx_shift;
    w_sda_oe_nxt   = r_sda_oe;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    w_tx_load_nxt  = 1'b0;
    w_busy_nxt     = r_busy;
    w_rw_flag_nxt  = r_rw_flag;

    if (w_stop) begin
      w_state_nxt  = StIdle;
      w_cnt_nxt    = 4'd0;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else if (w_start) begin
      w_state_nxt  = StAddr;
      w_cnt_nxt    = 4'd0;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_sda_oe_nxt = 1'b0;
          w_busy_nxt   = 1'b0;
        end

        StAddr: begin
          if (w_scl_rise && r_cnt < 4'd8) begin
            w_shift_nxt = {r_shift[6:0], w_sda};
            w_cnt_nxt   = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              // r_shift[6:0] holds the seven address bits at this point
              if (r_shift[6:0] == SLAVE_ADDR) begin
                w_rw_flag_nxt = w_sda;
                w_busy_nxt    = 1'b1;
              end else begin
                w_state_nxt = StIdle;
              end
            end
          end else if (w_scl_fall && r_cnt == 4'd8) begin
            w_sda_oe_nxt = 1'b1;
            w_state_nxt  = StAddrAck;
          end
        end

        StAddrAck: begin
          if (w_scl_fall) begin
            w_cnt_nxt = 4'd0;
            if (!r_rw_flag) begin
              w_sda_oe_nxt = 1'b0;
              w_state_nxt  = StWrData;
            end else begin
              w_tx_shift_nxt = bus.tx_data;
              w_tx_load_nxt  = 1'b1;
              w_sda_oe_nxt   = ~bus.tx_data[7];
              w_state_nxt    = StRdData;
            end
          end
        end

        StWrData: begin
          if (w_scl_rise && r_cnt < 4'd8) begin
            w_shift_nxt = {r_shift[6:0], w_sda};
            w_cnt_nxt   = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              w_rx_data_nxt  = {r_shift[6:0], w_sda};
              w_rx_valid_nxt = 1'b1;
            end
          end else if (w_scl_fall && r_cnt == 4'd8) begin
            w_sda_oe_nxt = 1'b1;
            w_state_nxt  = StWrAck;
          end
        end

        StWrAck: begin
          if (w_scl_fall) begin
            w_sda_oe_nxt = 1'b0;
            w_cnt_nxt    = 4'd0;
            w_state_nxt  = StWrData;
          end
        end

        StRdData: begin
          if (w_scl_rise && r_cnt < 4'd8) begin
            w_cnt_nxt = r_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_cnt == 4'd8) begin
              w_sda_oe_nxt = 1'b0;
              w_cnt_nxt    = 4'd0;
              w_state_nxt  = StRdAck;
            end else if (r_cnt != 4'd0) begin
              // MSB of the shifter is the bit on the wire; advance to the next
              w_tx_shift_nxt = {r_tx_shift[6:0], 1'b0};
              w_sda_oe_nxt   = ~r_tx_shift[6];
            end
          end
        end

        StRdAck: begin
          // r_cnt==1 records that the master ACKed on this clock
          if (w_scl_rise) begin
            if (w_sda) begin
              w_sda_oe_nxt = 1'b0;
              w_busy_nxt   = 1'b0;
              w_state_nxt  = StRdWait;
            end else begin
              w_cnt_nxt = 4'd1;
            end
          end else if (w_scl_fall && r_cnt == 4'd1) begin
            w_tx_shift_nxt = bus.tx_data;
            w_tx_load_nxt  = 1'b1;
            w_sda_oe_nxt   = ~bus.tx_data[7];
            w_cnt_nxt      = 4'd0;
            w_state_nxt    = StRdData;
          end
        end

        StRdWait: begin
          w_sda_oe_nxt = 1'b0;
          w_busy_nxt   = 1'b0;
        end

        default: begin
          w_state_nxt  = StIdle;
          w_sda_oe_nxt = 1'b0;
          w_busy_nxt   = 1'b0;
        end
      endcase
    end
  end

  assign bus.sda_oe   = r_sda_oe;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign bus.tx_load  = r_tx_load;
  assign bus.busy     = r_busy;
  assign bus.rw_flag  = r_rw_flag;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged bus master with an open-drain wire model,
// byte-level expectations derived from the address/direction rules.
module tb_i2c_slave;

  localparam logic [6:0] SlaveAddr = 7'h50;
  localparam int         Q         = 5;  // clk cycles per quarter SCL period

  logic clk = 1'b0;
  logic reset;
  logic m_scl;
  logic m_sda_low;
  logic sda_line;

  int checks = 0;
  int errors = 0;
  int tx_loads = 0;
  int overlap = 0;
  int oe_cnt = 0;
  logic [7:0] rx_seen[$];

  i2c_slave_if bus ();

  assign sda_line   = !(m_sda_low || (bus.sda_oe === 1'b1));
  assign bus.scl    = m_scl;
  assign bus.sda_in = sda_line;

  i2c_slave #(.SLAVE_ADDR(SlaveAddr)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Observe local-side pulses away from the active edge
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) rx_seen.push_back(bus.rx_data);
    if (bus.tx_load === 1'b1) tx_loads++;
    if (bus.rx_valid === 1'b1 && bus.tx_load === 1'b1) overlap++;
    if (bus.sda_oe === 1'b1) oe_cnt++;
  end

  task automatic wait_q();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  // Works from idle bus or from SCL low (repeated START)
  task automatic bus_start();
    m_sda_low = 1'b0; wait_q();
    m_scl     = 1'b1; wait_q();
    m_sda_low = 1'b1; wait_q();
    m_scl     = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; wait_q();
    m_scl     = 1'b1; wait_q();
    m_sda_low = 1'b0; wait_q();
  endtask

  task automatic clock_bit(input bit drive_low, output bit line, output bit oe);
    m_sda_low = drive_low; wait_q();
    m_scl     = 1'b1;      wait_q();
    line = sda_line;
    oe   = (bus.sda_oe === 1'b1);
    wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, output bit ack, output bit ack_oe,
                            output bit data_oe);
    bit line, oe;
    data_oe = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(!b[i], line, oe);
      data_oe |= oe;
    end
    clock_bit(1'b0, line, oe);
    ack    = !line;
    ack_oe = oe;
  endtask

  task automatic read_byte(input bit send_ack, input logic [7:0] next_tx,
                           output logic [7:0] got, output bit ack_oe);
    bit line, oe;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b0, line, oe);
      got[i] = line;
    end
    bus.tx_data = next_tx;
    clock_bit(send_ack, line, oe);
    ack_oe = oe;
  endtask

  // Write transfer; expectations follow from whether the address names this responder
  task automatic run_write(input logic [7:0] addr, input logic [7:0] data[$], input string tag);
    bit hit, ack, ack_oe, data_oe;
    int rx0, loads0, oe0;
    hit    = (addr[7:1] == SlaveAddr);
    rx0    = rx_seen.size();
    loads0 = tx_loads;
    oe0    = oe_cnt;
    bus_start();
    write_byte(addr, ack, ack_oe, data_oe);
    checks++;
    if (ack !== hit) begin
      errors++; $display("FAIL %s addr_ack: got %0b expected %0b", tag, ack, hit);
    end
    checks++;
    if (ack_oe !== hit) begin
      errors++; $display("FAIL %s addr_ack_oe: got %0b expected %0b", tag, ack_oe, hit);
    end
    checks++;
    if (bus.busy !== hit) begin
      errors++; $display("FAIL %s busy_after_addr: got %0b expected %0b", tag, bus.busy, hit);
    end
    if (hit) begin
      checks++;
      if (bus.rw_flag !== 1'b0) begin
        errors++; $display("FAIL %s rw_flag: got %0b expected 0", tag, bus.rw_flag);
      end
    end
    foreach (data[i]) begin
      write_byte(data[i], ack, ack_oe, data_oe);
      checks++;
      if (ack !== hit || ack_oe !== hit || data_oe !== 1'b0) begin
        errors++;
        $display("FAIL %s data_ack[%0d]: got ack=%0b oe=%0b data_oe=%0b expected ack=oe=%0b",
                 tag, i, ack, ack_oe, data_oe, hit);
      end
    end
    bus_stop();
    wait_q();
    checks++;
    if (rx_seen.size() - rx0 !== (hit ? data.size() : 0)) begin
      errors++;
      $display("FAIL %s rx_count: got %0d expected %0d", tag, rx_seen.size() - rx0,
               hit ? data.size() : 0);
    end else if (hit) begin
      foreach (data[i]) begin
        checks++;
        if (rx_seen[rx0 + i] !== data[i]) begin
          errors++;
          $display("FAIL %s rx_data[%0d]: got %h expected %h", tag, i, rx_seen[rx0 + i], data[i]);
        end
      end
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.sda_oe !== 1'b0 || tx_loads !== loads0) begin
      errors++;
      $display("FAIL %s after_stop: got busy=%0b oe=%0b loads=%0d expected 0 0 0",
               tag, bus.busy, bus.sda_oe, tx_loads - loads0);
    end
    if (!hit) begin
      checks++;
      if (oe_cnt !== oe0) begin
        errors++; $display("FAIL %s oe_never: got %0d cycles expected 0", tag, oe_cnt - oe0);
      end
    end
  endtask

  // Read transfer: ACK every byte but the last, NACK the last
  task automatic run_read(input logic [7:0] addr, input logic [7:0] tx[$], input string tag);
    bit hit, ack, ack_oe, data_oe;
    logic [7:0] got, exp, nxt;
    int rx0, loads0;
    hit    = (addr[7:1] == SlaveAddr);
    rx0    = rx_seen.size();
    loads0 = tx_loads;
    bus.tx_data = tx[0];
    bus_start();
    write_byte(addr, ack, ack_oe, data_oe);
    checks++;
    if (ack !== hit) begin
      errors++; $display("FAIL %s addr_ack: got %0b expected %0b", tag, ack, hit);
    end
    if (hit) begin
      checks++;
      if (bus.rw_flag !== 1'b1 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL %s rw_busy: got %0b %0b expected 1 1", tag, bus.rw_flag, bus.busy);
      end
    end
    foreach (tx[i]) begin
      nxt = (i + 1 < tx.size()) ? tx[i + 1] : 8'($urandom);
      read_byte(i + 1 < tx.size(), nxt, got, ack_oe);
      exp = hit ? tx[i] : 8'hFF;
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL %s rd_byte[%0d]: got %h expected %h", tag, i, got, exp);
      end
      checks++;
      if (ack_oe !== 1'b0) begin
        errors++; $display("FAIL %s master_ack_oe[%0d]: got %0b expected 0", tag, i, ack_oe);
      end
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL %s busy_after_nack: got %0b expected 0", tag, bus.busy);
    end
    bus_stop();
    wait_q();
    checks++;
    if (tx_loads - loads0 !== (hit ? tx.size() : 0)) begin
      errors++;
      $display("FAIL %s tx_loads: got %0d expected %0d", tag, tx_loads - loads0,
               hit ? tx.size() : 0);
    end
    checks++;
    if (rx_seen.size() !== rx0 || bus.sda_oe !== 1'b0) begin
      errors++;
      $display("FAIL %s read_side: got rx=%0d oe=%0b expected 0 0", tag,
               rx_seen.size() - rx0, bus.sda_oe);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.sda_oe, bus.rx_data, bus.rx_valid, bus.tx_load, bus.busy, bus.rw_flag} !== 13'h0)
    begin
      errors++;
      $display("FAIL reset_values: got oe=%0b rx=%h v=%0b ld=%0b busy=%0b rw=%0b expected all 0",
               bus.sda_oe, bus.rx_data, bus.rx_valid, bus.tx_load, bus.busy, bus.rw_flag);
    end
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_write();
    logic [7:0] d[$];
    d = {8'hA5, 8'h5A};
    run_write(8'hA0, d, "write");
  endtask

  task automatic test_wrong_addr();
    logic [7:0] d[$];
    d = {8'hFF};
    run_write(8'hA2, d, "wrong_addr");
  endtask

  task automatic test_read();
    logic [7:0] t[$];
    t = {8'hAA, 8'h3C};
    run_read(8'hA1, t, "read");
  endtask

  task automatic test_repeated_start();
    bit ack, ack_oe, data_oe;
    logic [7:0] t, got;
    int loads0, rx0;
    t      = 8'($urandom);
    loads0 = tx_loads;
    rx0    = rx_seen.size();
    bus_start();
    write_byte(8'hA0, ack, ack_oe, data_oe);
    write_byte(8'h11, ack, ack_oe, data_oe);
    checks++;
    if (bus.rw_flag !== 1'b0 || ack !== 1'b1) begin
      errors++; $display("FAIL rstart_write: got rw=%0b ack=%0b expected 0 1", bus.rw_flag, ack);
    end
    bus.tx_data = t;
    bus_start();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL rstart_busy_clear: got %0b expected 0", bus.busy);
    end
    write_byte(8'hA1, ack, ack_oe, data_oe);
    checks++;
    if (ack !== 1'b1 || bus.rw_flag !== 1'b1 || tx_loads - loads0 !== 1) begin
      errors++;
      $display("FAIL rstart_readdr: got ack=%0b rw=%0b loads=%0d expected 1 1 1",
               ack, bus.rw_flag, tx_loads - loads0);
    end
    read_byte(1'b0, 8'h00, got, ack_oe);
    checks++;
    if (got !== t) begin
      errors++; $display("FAIL rstart_rd_byte: got %h expected %h", got, t);
    end
    bus_stop();
    wait_q();
    checks++;
    if (bus.rx_data !== 8'h11 || rx_seen.size() - rx0 !== 1 || tx_loads - loads0 !== 1) begin
      errors++;
      $display("FAIL rstart_totals: got rx=%h n=%0d loads=%0d expected 11 1 1",
               bus.rx_data, rx_seen.size() - rx0, tx_loads - loads0);
    end
  endtask

  task automatic test_stop_mid_byte();
    bit ack, ack_oe, data_oe, line, oe;
    logic [7:0] prev;
    int rx0;
    prev = bus.rx_data;
    rx0  = rx_seen.size();
    bus_start();
    write_byte(8'hA0, ack, ack_oe, data_oe);
    for (int i = 0; i < 4; i++) clock_bit(1'($urandom), line, oe);
    bus_stop();
    wait_q();
    checks++;
    if (rx_seen.size() !== rx0 || bus.rx_data !== prev || bus.busy !== 1'b0 ||
        bus.sda_oe !== 1'b0) begin
      errors++;
      $display("FAIL stop_mid_byte: got n=%0d rx=%h busy=%0b oe=%0b expected 0 %h 0 0",
               rx_seen.size() - rx0, bus.rx_data, bus.busy, bus.sda_oe, prev);
    end
  endtask

  task automatic test_random_traffic();
    logic [7:0] q[$];
    logic [6:0] a;
    bit rw;
    for (int it = 0; it < 8; it++) begin
      rw = 1'($urandom);
      a  = ($urandom_range(0, 3) != 0) ? SlaveAddr : 7'($urandom);
      if (it == 0) a = SlaveAddr ^ 7'h01;
      q = {};
      for (int n = $urandom_range(1, 3); n > 0; n--) q.push_back(8'($urandom));
      if (rw) run_read({a, 1'b1}, q, "random_read");
      else    run_write({a, 1'b0}, q, "random_write");
    end
  endtask

  task automatic test_reset_mid_read();
    bit ack, ack_oe, data_oe, line, oe;
    logic [7:0] d[$];
    bus.tx_data = 8'hE7;  // bit 3 (MSB first) is 0, so the responder pulls SDA low
    bus_start();
    write_byte(8'hA1, ack, ack_oe, data_oe);
    for (int i = 0; i < 3; i++) clock_bit(1'b0, line, oe);
    checks++;
    if (bus.sda_oe !== 1'b1) begin
      errors++; $display("FAIL pre_reset_drive: got %0b expected 1", bus.sda_oe);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.sda_oe, bus.rx_data, bus.rx_valid, bus.tx_load, bus.busy, bus.rw_flag} !== 13'h0)
    begin
      errors++;
      $display("FAIL mid_read_reset: got oe=%0b rx=%h v=%0b ld=%0b busy=%0b rw=%0b expected 0",
               bus.sda_oe, bus.rx_data, bus.rx_valid, bus.tx_load, bus.busy, bus.rw_flag);
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    wait_q();
    d = {8'hA5};
    run_write(8'hA0, d, "post_reset_write");
  endtask

  task automatic test_no_overlap();
    checks++;
    if (overlap !== 0) begin
      errors++; $display("FAIL rx_valid_tx_load_overlap: got %0d cycles expected 0", overlap);
    end
  endtask

  initial begin
    reset       = 1'b0;
    m_scl       = 1'b1;
    m_sda_low   = 1'b0;
    bus.tx_data = 8'h00;
    #2;
    test_reset();
    test_write();
    test_wrong_addr();
    test_read();
    test_repeated_start();
    test_stop_mid_byte();
    test_random_traffic();
    test_reset_mid_read();
    test_no_overlap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C responder for the other end of the bus driven by I2C_Master.
- Oversamples SCL/SDA on the system clock, detects START/STOP, and matches a 7-bit address.
- For master writes, it receives bytes and ACKs each one. For master reads, it transmits bytes supplied by local logic.
- SDA is driven open-drain through an output-enable, so it works with a pulled-up bus wire at top level.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit bus address this responder ACKs.

Ports:
- clk  input  1  system clock; SCL high and low phases must each last at least 4 clk cycles.
- reset  input  1  asynchronous, active-high reset.
- scl  input  1  bus clock (raw, asynchronous to clk).
- sda_in  input  1  bus data as read from the wire (raw).
- sda_oe  output  1  1 = pull SDA low; 0 = release (high-Z at top level).
- rx_data  output  8  last byte received in a write transfer.
- rx_valid  output  1  one-clk pulse when rx_data updates.
- tx_data  input  8  byte to send in a read transfer; sampled on a tx_load pulse.
- tx_load  output  1  one-clk pulse when tx_data is latched into the shifter.
- busy  output  1  high from an address match until STOP, NACK end, or a new START.
- rw_flag  output  1  R/W bit of the current addressed transfer (1 = read).

Behaviour:
- Reset: asynchronous, active-high. sda_oe=0, rx_data=8'h00, rx_valid=0, tx_load=0, busy=0, rw_flag=0, state=IDLE, bit counter=0.
- Input synchronisation: 2-flop synchronisers on scl and sda_in, plus a previous-value register. All edges are seen 2–3 clks after the pin changes.
- Bus events:
  - scl_rise / scl_fall: edges of synced SCL.
  - START: synced SDA falls while synced SCL is high.
  - STOP: synced SDA rises while synced SCL is high.
  - START and STOP are evaluated before data sampling in the same cycle.
- Bit timing: data is sampled on scl_rise. sda_oe changes only on scl_fall, except STOP, START and reset, which clear it immediately.
- States:
  - IDLE: sda_oe=0, busy=0. START -> ADDR with bit counter=0.
  - ADDR: shift in 8 bits MSB first on scl_rise. After the 8th bit:
    - If bits[7:1]==SLAVE_ADDR: latch rw_flag=bit0 and set busy=1. On the next scl_fall, set sda_oe=1 and go to ADDR_ACK.
    - Otherwise go to IDLE. No ACK is driven, and bits are ignored until the next START.
  - ADDR_ACK: on scl_fall, release the ACK.
    - If rw_flag=0: go to WR_DATA, sda_oe=0.
    - If rw_flag=1: latch tx_data, pulse tx_load, drive sda_oe=~tx_data[7], go to RD_DATA.
  - WR_DATA: shift in 8 bits on scl_rise. After the 8th bit, update rx_data and pulse rx_valid in the same cycle. On the next scl_fall, set sda_oe=1 and go to WR_ACK.
  - WR_ACK: on scl_fall, set sda_oe=0 and go to WR_DATA. Every received byte is ACKed; there is no flow control.
  - RD_DATA: on each scl_fall after a bit is sampled, drive sda_oe=~next bit, MSB first. On the scl_fall after the 8th bit, set sda_oe=0 (release for the master ACK) and go to RD_ACK.
  - RD_ACK: sample on scl_rise.
    - SDA=0 (ACK): on the next scl_fall, latch new tx_data, pulse tx_load, drive its MSB, go to RD_DATA.
    - SDA=1 (NACK): go to RD_WAIT with sda_oe=0.
  - RD_WAIT: sda_oe=0. Wait for STOP or START.
- Boundary conditions:
  - STOP in any state: go to IDLE, sda_oe=0, busy=0. A partial byte is discarded and rx_valid is not pulsed.
  - START (repeated) in any state: go to ADDR, bit counter=0, sda_oe=0, busy=0 until the address is rematched.
  - START while sda_oe=1: cannot legally occur, because the master does not pull SDA low while the slave drives it. sda_oe is still cleared.
  - Reset mid-transfer: immediate return to reset values. The block re-engages only on the next START.
  - rx_valid and tx_load are never both high in the same cycle.

Test Plan:
- Write, matching address:
  - Stimulus: START, address byte 0xA0 (0x50, W), data 0xA5 and 0x5A, STOP.
  - Required: sda_oe=1 during all three ACK clocks; rx_valid pulses twice with rx_data=0xA5 then 0x5A; busy 1->0 at STOP.
- Wrong address:
  - Stimulus: START, address byte 0xA2 (0x51, W), data 0xFF.
  - Required: sda_oe stays 0 throughout; no rx_valid; busy=0.
- Read:
  - Stimulus: START, address byte 0xA1, tx_data=0xAA; master ACKs, then tx_data=0x3C; master NACKs, STOP.
  - Required: tx_load pulses twice; SDA pattern 10101010 then 00111100; sda_oe=0 during both master-ACK clocks; state returns to IDLE.
- Repeated START:
  - Stimulus: START, 0xA0, 0x11, repeated START, 0xA1, read one byte with NACK, STOP.
  - Required: rx_data=0x11; rw_flag 0->1; one tx_load after the second address ACK.
- STOP mid-byte:
  - Stimulus: START, 0xA0, then 4 data bits, then STOP.
  - Required: no rx_valid; rx_data unchanged; busy=0; sda_oe=0.
- Reset mid-read:
  - Stimulus: assert reset while driving bit 3 of a read byte.
  - Required: sda_oe=0 immediately (async); all outputs at reset values; the next full write transfer with 0xA5 succeeds normally.
